// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, PC step,
// and the fetch entry layout ({pc, instr}) held in the prefetch FIFO.
package if_fetch_queue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no request outstanding
        WAIT = 2'd1,   // request outstanding, data will be kept
        DROP = 2'd2    // request outstanding, data is stale after a redirect
    } fetch_state_e;

    localparam int unsigned PC_STEP       = 4;
    localparam int unsigned FETCH_ADDR_W  = 32;
    localparam int unsigned FETCH_INSTR_W = 32;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Synchronous prefetch FIFO with flush. DEPTH must be a power of two so the
// pointers wrap naturally; count is one bit wider to represent "full".
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Storage is not reset; the top masks the head while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one word read at a
// time to instruction memory, buffers returns in a prefetch FIFO for decode,
// and flushes on redirect. Optional stall/flush counters under the macro
// IF_FETCH_STATS_EN.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter int               INSTR_W  = 32,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready
`ifdef IF_FETCH_STATS_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);
    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);

    fetch_state_e             state, state_nxt;
    logic [ADDR_W-1:0]        fetch_pc;
    logic [ADDR_W-1:0]        req_pc;
    logic [CNT_W-1:0]         count;
    logic [CNT_W:0]           count_after;
    logic [ADDR_W+INSTR_W-1:0] head;
    logic                     push, pop, issue;

    fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W + INSTR_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({req_pc, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count)
    );

    assign if_valid    = (count != '0);
    assign pop         = if_valid && id_ready && !redirect;
    // Occupancy if this cycle's ack is pushed alongside any pop.
    assign count_after = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);

    assign imem_req  = (state != IDLE);
    assign imem_addr = req_pc;
    assign if_pc     = if_valid ? head[ADDR_W+INSTR_W-1:INSTR_W] : '0;
    assign if_instr  = if_valid ? head[INSTR_W-1:0] : '0;

    // Next state, push and issue; a slot is always reserved before issuing.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect && ({1'b0, count} < DEPTH_C)) begin
                    state_nxt = WAIT;
                    issue     = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_nxt = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push = 1'b1;
                    if (count_after < DEPTH_C) issue     = 1'b1;
                    else                       state_nxt = IDLE;
                end
            end
            DROP: begin
                // Stale data is discarded; the FIFO is empty so reissue directly.
                if (imem_ack) begin
                    if (redirect) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                        issue     = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, fetch PC and the address of the outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            end
        end
    end

`ifdef IF_FETCH_STATS_EN
    logic [32:0] flush_sum;
    assign flush_sum = {1'b0, flush_cnt} + 33'(count) + 33'(state != IDLE);

    // Saturating stall and flushed-entry counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (if_valid && !id_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect)
                flush_cnt <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the pipelined core's IF/ID register.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode with valid/ready.
- Flushes the FIFO and any in-flight read on a branch/jump redirect from the core's PC-source logic.

Parameters:
- ADDR_W, 32, fetch address width in bits.
- INSTR_W, 32, instruction word width in bits.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request; held high until imem_ack.
- imem_addr  out  ADDR_W  word-aligned read address; stable while imem_req is high.
- imem_ack  in  1  one-cycle pulse: imem_rdata is valid this cycle.
- imem_rdata  in  INSTR_W  returned instruction.
- redirect  in  1  one-cycle pulse from the core (taken beq/bneq or jump).
- redirect_pc  in  ADDR_W  new fetch target; bits [1:0] are ignored and treated as 0.
- if_valid  out  1  FIFO head holds an instruction.
- if_instr  out  INSTR_W  FIFO head instruction.
- if_pc  out  ADDR_W  PC of the FIFO head.
- id_ready  in  1  decode accepts the head this cycle; low means stall.

Behaviour:
- Reset (rst low, async):
  - fetch_pc = RESET_PC; FIFO empty; state IDLE; imem_req = 0; if_valid = 0.
  - if_instr and if_pc read 0; counters are cleared.
  - Reset asserted mid-request abandons the request. An ack arriving after reset release while in IDLE is ignored.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DROP: request outstanding, but its data is stale because of a redirect.
- IDLE to WAIT: when count < DEPTH and no redirect this cycle.
  - Drive imem_req = 1 and imem_addr = fetch_pc from the next cycle.
  - Latch req_pc = fetch_pc and set fetch_pc += 4 (wraps modulo 2^ADDR_W).
- WAIT on imem_ack:
  - Push {req_pc, imem_rdata} into the FIFO.
  - If count after push and pop is still < DEPTH, go back-to-back: reissue next cycle without returning to IDLE. Otherwise go to IDLE.
- DROP on imem_ack: discard the data, then issue from the redirect target on the following cycle.
- Credit rule: at most one request is outstanding, and a request is issued only when a free slot is reserved for it. The FIFO therefore never overflows, and the push is never blocked.
- Decode side:
  - if_valid = (count != 0).
  - A pop occurs when if_valid && id_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Latency: ack in cycle N gives if_valid in cycle N+1 (no bypass).
- Redirect (highest priority):
  - Same edge: FIFO emptied, fetch_pc = redirect_pc.
  - If in WAIT, go to DROP. If an ack coincides with the redirect, that data is dropped and the state goes to IDLE.
  - A pop in the same cycle is discarded.
  - A redirect while already in DROP only updates fetch_pc.
- imem_req is deasserted in the cycle after ack unless back-to-back issue applies. The address never changes while req is high.

Optional Feature:
- Macro: IF_FETCH_STATS_EN.
- When defined, two extra outputs are added:
  - stall_cnt (32 bits): increments each cycle with if_valid && !id_ready.
  - flush_cnt (32 bits): on each redirect, adds the number of entries discarded (FIFO count plus 1 if a request is in flight).
- Both counters saturate at all-ones and clear on reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - fetch FSM state enum {IDLE, WAIT, DROP};
  - PC_STEP = 4;
  - the fetch-entry struct {pc, instr}.
- One sub-module: fetch_fifo, a parameterised synchronous FIFO (DEPTH, entry width) with push/pop/flush and count.
- The FSM and PC logic stay in the top.

Test Plan:
- Reset release, memory acking 1 cycle after each req, id_ready = 1: addresses 0x0, 0x4, 0x8 issued in order; if_pc follows 0x0, 0x4, 0x8 with matching instructions.
- id_ready held low: exactly 4 entries fill; imem_req stays low while full; raising id_ready drains 0x0..0xC in order and fetch resumes at 0x10.
- Redirect to 0x100 while a request to 0x8 is in flight: the ack for 0x8 is discarded, the next req address is 0x100, and the FIFO is empty in the cycle after the redirect.
- Redirect in the same cycle as imem_ack and a pop: nothing is pushed, the head is not delivered, and the next req is to redirect_pc.
- fetch_pc = 0xFFFF_FFFC: next issued address is 0x0000_0000; redirect_pc = 0x103 fetches 0x100.
- rst pulsed low mid-WAIT with IF_FETCH_STATS_EN defined: all outputs return to reset values immediately; stall_cnt and flush_cnt read 0; fetch restarts at RESET_PC.
